// File: rtl/ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ctrl_pkg                                                                     |
// | Shared encodings for the RV32I multi-cycle control unit.                     |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_WB     = 4'd5,
    S_ADDR   = 4'd6,
    S_MEM_RD = 4'd7,
    S_MEM_WR = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    CLS_R     = 2'd0,
    CLS_I     = 2'd1,
    CLS_OTHER = 2'd2
  } op_class_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JAL    = 2'd2;

  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_UIMM = 2'd1;
  localparam logic [1:0] WD_MEM  = 2'd2;
  localparam logic [1:0] WD_PC4  = 2'd3;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_fsm_alu_dec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_dec                                                                      |
// | Combinational ALU-op decode from opcode class, funct3 and funct7.            |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module alu_dec
  import ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 4
) (
  input  op_class_e             op_class,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  output logic [ALU_OP_W-1:0]   alu_op,
  output logic                  r_illegal
);

  logic [3:0] w_op;
  logic       w_alt;

  always_comb begin
    w_alt     = 1'b0;
    r_illegal = 1'b0;
    w_op      = ALU_ADD;
    case (op_class)
      CLS_R: begin
        w_alt     = funct7[5];
        r_illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      // Immediate forms never subtract; funct7[5] only selects SRA for shifts.
      CLS_I:   w_alt = (funct3 == 3'b101) && funct7[5];
      default: w_alt = 1'b0;
    endcase
    case (funct3)
      3'b000:  w_op = w_alt ? ALU_SUB : ALU_ADD;
      3'b001:  w_op = ALU_SLL;
      3'b010:  w_op = ALU_SLT;
      3'b011:  w_op = ALU_SLTU;
      3'b100:  w_op = ALU_XOR;
      3'b101:  w_op = w_alt ? ALU_SRA : ALU_SRL;
      3'b110:  w_op = ALU_OR;
      default: w_op = ALU_AND;
    endcase
    if (op_class == CLS_OTHER) w_op = ALU_ADD;
  end

  assign alu_op = ALU_OP_W'(w_op);

endmodule
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mc_ctrl_fsm                                                                  |
// | Multi-cycle RV32I control FSM driving PC/IR/regfile/ALU/memory controls.     |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module mc_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 4,
  parameter bit HAS_MEM  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                ir_write,
  output logic                reg_write,
  output logic                rs2_imm_s,
  output logic [1:0]          w_data_s,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal,
  output logic [3:0]          state
);

  state_e                r_state;
  state_e                w_next;
  logic [1:0]            r_wb_sel;
  logic                  r_is_store;
  op_class_e             w_class;
  logic [ALU_OP_W-1:0]   w_dec_op;
  logic                  w_r_illegal;

  assign w_class = (r_state == S_EXEC_R || (r_state == S_DECODE && opcode == OP_R)) ? CLS_R :
                   (r_state == S_EXEC_I) ? CLS_I : CLS_OTHER;

  alu_dec #(.ALU_OP_W(ALU_OP_W)) u_alu_dec (
    .op_class  (w_class),
    .funct3    (funct3),
    .funct7    (funct7),
    .alu_op    (w_dec_op),
    .r_illegal (w_r_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Instruction class captured in DECODE so later states never look at the opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_sel   <= WD_ALU;
      r_is_store <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_wb_sel   <= (opcode == OP_LUI) ? WD_UIMM : (opcode == OP_LOAD) ? WD_MEM : WD_ALU;
      r_is_store <= (opcode == OP_STORE);
    end
  end

  always_comb begin
    w_next    = S_IDLE;
    pc_write  = 1'b0;
    pc_src    = PC_SRC_PLUS4;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    rs2_imm_s = 1'b0;
    w_data_s  = WD_ALU;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    alu_op    = '0;
    illegal   = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        w_next  = S_FETCH;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        w_next = S_FETCH;
        case (opcode)
          OP_R:     if (w_r_illegal) illegal = 1'b1; else w_next = S_EXEC_R;
          OP_I:     w_next = S_EXEC_I;
          OP_LUI:   w_next = S_WB;
          OP_LOAD, OP_STORE: if (HAS_MEM) w_next = S_ADDR; else illegal = 1'b1;
          OP_BRANCH: if (funct3 == F3_BEQ || funct3 == F3_BNE) w_next = S_BRANCH;
                     else illegal = 1'b1;
          OP_JAL:   w_next = S_JAL;
          default:  illegal = 1'b1;
        endcase
      end
      S_EXEC_R: begin
        alu_op = w_dec_op;
        w_next = S_WB;
      end
      S_EXEC_I: begin
        alu_op    = w_dec_op;
        rs2_imm_s = 1'b1;
        w_next    = S_WB;
      end
      S_WB: begin
        reg_write = 1'b1;
        w_data_s  = r_wb_sel;
        w_next    = S_FETCH;
      end
      S_ADDR: begin
        alu_op    = ALU_OP_W'(ALU_ADD);
        rs2_imm_s = 1'b1;
        w_next    = r_is_store ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        w_next  = mem_ready ? S_WB : S_MEM_RD;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        w_next  = mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_BRANCH: begin
        alu_op   = ALU_OP_W'(ALU_SUB);
        pc_write = (funct3 == F3_BEQ) ? zero : ~zero;
        pc_src   = PC_SRC_BRANCH;
        w_next   = S_FETCH;
      end
      S_JAL: begin
        reg_write = 1'b1;
        w_data_s  = WD_PC4;
        pc_write  = 1'b1;
        pc_src    = PC_SRC_JAL;
        w_next    = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mc_ctrl_fsm                                                               |
// | Self-checking bench: per-instruction cycle plans compared every cycle.       |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_mc_ctrl_fsm;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, reg_write, rs2_imm_s, mem_req, mem_we, illegal;
  logic [1:0] pc_src, w_data_s;
  logic [3:0] alu_op, state;

  logic       nm_pc_write, nm_ir_write, nm_reg_write, nm_rs2_imm_s, nm_mem_req, nm_mem_we, nm_illegal;
  logic [1:0] nm_pc_src, nm_w_data_s;
  logic [3:0] nm_alu_op, nm_state;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.ALU_OP_W(4), .HAS_MEM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .reg_write(reg_write), .rs2_imm_s(rs2_imm_s), .w_data_s(w_data_s),
    .mem_req(mem_req), .mem_we(mem_we), .alu_op(alu_op), .illegal(illegal), .state(state)
  );

  // Memory-less variant fed a permanent LW with an always-ready memory.
  mc_ctrl_fsm #(.ALU_OP_W(4), .HAS_MEM(1'b0)) dut_nm (
    .clk(clk), .rst_n(rst_n), .opcode(7'b0000011), .funct3(3'b010), .funct7(7'b0000000),
    .zero(1'b0), .mem_ready(1'b1), .pc_write(nm_pc_write), .pc_src(nm_pc_src),
    .ir_write(nm_ir_write), .reg_write(nm_reg_write), .rs2_imm_s(nm_rs2_imm_s),
    .w_data_s(nm_w_data_s), .mem_req(nm_mem_req), .mem_we(nm_mem_we), .alu_op(nm_alu_op),
    .illegal(nm_illegal), .state(nm_state)
  );

  typedef struct {
    logic       mr;
    logic [3:0] st;
    logic       pcw;
    logic [1:0] pcs;
    logic       irw;
    logic       rw;
    logic       imm;
    logic [1:0] wds;
    logic       req;
    logic       we;
    logic [3:0] alu;
    logic       ill;
  } cyc_t;

  int    checks = 0;
  int    errors = 0;
  cyc_t  plan[$];
  cyc_t  exp_c;
  logic  exp_valid = 1'b0;
  string tag = "init";

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic cyc_t blank(input logic [3:0] st);
    cyc_t c;
    c.mr = 1'b1; c.st = st; c.pcw = 1'b0; c.pcs = 2'd0; c.irw = 1'b0; c.rw = 1'b0;
    c.imm = 1'b0; c.wds = 2'd0; c.req = 1'b0; c.we = 1'b0; c.alu = 4'd0; c.ill = 1'b0;
    return c;
  endfunction

  // RV32I ALU operation implied by funct3 plus the alternate (SUB/SRA) bit.
  function automatic logic [3:0] isa_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0: return alt ? 4'd1 : 4'd0;
      3'd1: return 4'd2;
      3'd2: return 4'd3;
      3'd3: return 4'd4;
      3'd4: return 4'd5;
      3'd5: return alt ? 4'd7 : 4'd6;
      3'd6: return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  // Expected cycle-by-cycle outputs for one instruction from its architectural meaning.
  task automatic build(input logic [31:0] ins, input int fw, input int mw, input logic z);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    cyc_t c;
    string kind;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    plan.delete();
    for (int i = 0; i < fw; i++) begin
      c = blank(S_FETCH); c.mr = 1'b0; c.req = 1'b1; plan.push_back(c);
    end
    c = blank(S_FETCH); c.req = 1'b1; c.irw = 1'b1; c.pcw = 1'b1; plan.push_back(c);
    if (op == 7'h33 && (f7 == 7'h00 || f7 == 7'h20)) kind = "r";
    else if (op == 7'h13) kind = "i";
    else if (op == 7'h37) kind = "lui";
    else if (op == 7'h03) kind = "ld";
    else if (op == 7'h23) kind = "st";
    else if (op == 7'h63 && f3 <= 3'd1) kind = "br";
    else if (op == 7'h6F) kind = "jal";
    else kind = "ill";
    c = blank(S_DECODE); c.ill = (kind == "ill"); plan.push_back(c);
    if (kind == "r" || kind == "i") begin
      c = blank(kind == "r" ? S_EXEC_R : S_EXEC_I);
      c.imm = (kind == "i");
      c.alu = isa_alu(f3, kind == "r" ? f7[5] : (f3 == 3'd5 && f7[5]));
      plan.push_back(c);
      c = blank(S_WB); c.rw = 1'b1; plan.push_back(c);
    end else if (kind == "lui") begin
      c = blank(S_WB); c.rw = 1'b1; c.wds = 2'd1; plan.push_back(c);
    end else if (kind == "ld" || kind == "st") begin
      c = blank(S_ADDR); c.imm = 1'b1; plan.push_back(c);
      for (int i = 0; i <= mw; i++) begin
        c = blank(kind == "ld" ? S_MEM_RD : S_MEM_WR);
        c.req = 1'b1; c.we = (kind == "st"); c.mr = (i == mw);
        plan.push_back(c);
      end
      if (kind == "ld") begin
        c = blank(S_WB); c.rw = 1'b1; c.wds = 2'd2; plan.push_back(c);
      end
    end else if (kind == "br") begin
      c = blank(S_BRANCH); c.alu = 4'd1; c.pcs = 2'd1;
      c.pcw = (f3 == 3'd0) ? z : !z;
      plan.push_back(c);
    end else if (kind == "jal") begin
      c = blank(S_JAL); c.rw = 1'b1; c.wds = 2'd3; c.pcw = 1'b1; c.pcs = 2'd2;
      plan.push_back(c);
    end
  endtask

  task automatic run(input string nm, input logic [31:0] ins, input int fw, input int mw,
                     input logic z, input int stop);
    build(ins, fw, mw, z);
    tag = nm;
    opcode = ins[6:0]; funct3 = ins[14:12]; funct7 = ins[31:25]; zero = z;
    for (int i = 0; i < plan.size(); i++) begin
      if (stop >= 0 && i == stop) break;
      mem_ready = plan[i].mr;
      exp_c = plan[i];
      exp_valid = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    exp_valid = 1'b0;
  endtask

  task automatic idle_cycle(input string nm);
    tag = nm;
    exp_c = blank(S_IDLE);
    exp_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".state"}, 32'(state), 32'(S_IDLE));
    chk({nm, ".outs"}, 32'({pc_write, pc_src, ir_write, reg_write, rs2_imm_s, w_data_s,
                            mem_req, mem_we, alu_op, illegal}), 32'd0);
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      chk({tag, ".state"},     32'(state),     32'(exp_c.st));
      chk({tag, ".pc_write"},  32'(pc_write),  32'(exp_c.pcw));
      chk({tag, ".pc_src"},    32'(pc_src),    32'(exp_c.pcs));
      chk({tag, ".ir_write"},  32'(ir_write),  32'(exp_c.irw));
      chk({tag, ".reg_write"}, 32'(reg_write), 32'(exp_c.rw));
      chk({tag, ".rs2_imm_s"}, 32'(rs2_imm_s), 32'(exp_c.imm));
      chk({tag, ".w_data_s"},  32'(w_data_s),  32'(exp_c.wds));
      chk({tag, ".mem_req"},   32'(mem_req),   32'(exp_c.req));
      chk({tag, ".mem_we"},    32'(mem_we),    32'(exp_c.we));
      chk({tag, ".alu_op"},    32'(alu_op),    32'(exp_c.alu));
      chk({tag, ".illegal"},   32'(illegal),   32'(exp_c.ill));
    end
  end

  initial begin
    @(posedge rst_n);
    @(negedge clk);
    chk("nm.idle", 32'(nm_state), 32'(S_IDLE));
    @(negedge clk);
    chk("nm.fetch", 32'(nm_state), 32'(S_FETCH));
    chk("nm.fetch_irw", 32'(nm_ir_write), 32'd1);
    @(negedge clk);
    chk("nm.decode", 32'(nm_state), 32'(S_DECODE));
    chk("nm.illegal", 32'(nm_illegal), 32'd1);
    chk("nm.no_write", 32'({nm_reg_write, nm_mem_req, nm_pc_write}), 32'd0);
    @(negedge clk);
    chk("nm.next_fetch", 32'(nm_state), 32'(S_FETCH));
    chk("nm.pulse_end", 32'(nm_illegal), 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    mem_ready = 1'b1;
    opcode = 7'h33;
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycle("idle");

    run("add", 32'h002081B3, 0, 0, 1'b0, -1);
    chk("pin.add_len", 32'(plan.size()), 32'd4);
    chk("pin.add_alu", 32'(plan[2].alu), 32'd0);
    chk("pin.add_rw", 32'(plan[3].rw), 32'd1);
    run("sub",   32'h402081B3, 0, 0, 1'b0, -1);
    run("sra",   32'h4020D1B3, 1, 0, 1'b0, -1);
    run("and",   32'h0020F1B3, 0, 0, 1'b0, -1);
    run("srai",  32'h4050D193, 0, 0, 1'b0, -1);
    chk("pin.srai_alu", 32'(plan[2].alu), 32'd7);
    chk("pin.srai_imm", 32'(plan[2].imm), 32'd1);
    run("addi",  32'h40008193, 0, 0, 1'b0, -1);
    chk("pin.addi_alu", 32'(plan[2].alu), 32'd0);
    run("sltiu", 32'h0010B193, 0, 0, 1'b0, -1);
    run("lui",   32'h123451B7, 0, 0, 1'b0, -1);
    chk("pin.lui_len", 32'(plan.size()), 32'd3);
    run("lw",    32'h0000A183, 3, 2, 1'b0, -1);
    chk("pin.lw_len", 32'(plan.size()), 32'd10);
    chk("pin.lw_wds", 32'(plan[9].wds), 32'd2);
    run("sw",    32'h0030A023, 0, 1, 1'b0, -1);
    chk("pin.sw_len", 32'(plan.size()), 32'd5);
    run("beq_z1", 32'h00208463, 0, 0, 1'b1, -1);
    chk("pin.beq_pcw", 32'(plan[2].pcw), 32'd1);
    run("bne_z1", 32'h00209463, 0, 0, 1'b1, -1);
    chk("pin.bne_pcw", 32'(plan[2].pcw), 32'd0);
    run("bne_z0", 32'h00209463, 0, 0, 1'b0, -1);
    run("beq_z0", 32'h00208463, 0, 0, 1'b0, -1);
    run("jal",   32'h008000EF, 0, 0, 1'b0, -1);
    run("op7f",  32'h0000007F, 0, 0, 1'b0, -1);
    chk("pin.ill_len", 32'(plan.size()), 32'd2);
    chk("pin.ill_flag", 32'(plan[1].ill), 32'd1);
    run("r_f7bad", 32'h022081B3, 0, 0, 1'b0, -1);
    run("blt",   32'h0020C463, 0, 0, 1'b0, -1);
    run("add2",  32'h002081B3, 2, 0, 1'b0, -1);

    // Abort a load while it is stalled in MEM_RD.
    run("lw_abort", 32'h0000A183, 0, 5, 1'b0, 5);
    chk("mid.state", 32'(state), 32'(S_MEM_RD));
    chk("mid.mem_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycle("idle2");
    run("add_after", 32'h002081B3, 0, 0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
